sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single-port 32K x 256-bit SRAM between NUM_REQ requesters.
- Accepts one read or write per cycle over a req/gnt handshake and drives the registered SRAM address, data, write-enable and valid strobes.
- Returns read data to the issuing requester with a fixed 2-cycle latency.
- Sits between the client blocks and the SRAM macro/interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 15, SRAM word address width.
- DATA_W, 256, SRAM data width.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; held high until granted.
- req_we  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  packed write data.
- gnt  output  NUM_REQ  one-hot accept; transfer occurs on a posedge where req[i] & gnt[i].
- rvalid  output  NUM_REQ  one-hot, one-cycle read-return strobe.
- rdata  output  DATA_W  read data, shared by all requesters, qualified by rvalid.
- sram_addr  output  ADDR_W  registered SRAM address.
- sram_din  output  DATA_W  registered SRAM write data.
- sram_we  output  1  registered write enable.
- sram_valid  output  1  registered access strobe (valid_tx).
- sram_dout  input  DATA_W  SRAM read data, valid the cycle after the access edge.

Behaviour:
- Reset values: gnt, rvalid, sram_we, sram_valid = 0; rdata, sram_addr, sram_din = 0; RR pointer = 0; read-tag pipeline cleared.
- Arbitration (combinational gnt):
  - Winner is the first asserted req at or after the pointer, searching upward with wrap-around from NUM_REQ-1 to 0.
  - At most one gnt bit is high per cycle.
  - gnt = 0 when req = 0.
- Pointer update: on each accept edge the pointer becomes winner+1 mod NUM_REQ. It is unchanged when nothing is granted.
- Issue stage (E0 = accept edge):
  - sram_addr, sram_we and sram_din load from the winner; sram_valid = 1 for the cycle following E0.
  - With no accept, sram_valid = 0 and sram_we = 0. sram_addr and sram_din hold their last values.
- Read return:
  - The SRAM samples at E1. The block registers sram_dout into rdata at E2 and pulses rvalid[winner] for one cycle after E2.
  - Latency from accept edge to rvalid: 2 cycles.
- Writes: no return strobe. A write is complete at E1.
- Throughput: one access per cycle, with back-to-back accepts from any mix of requesters.
- Read-tag pipeline: 2 stages of {valid, index, is_read}, so the issuing requester is tracked independently per in-flight op.
- Hazard: a read issued the cycle after a write to the same address returns the new data; SRAM write-then-read ordering is preserved by the in-order pipeline.
- No backpressure on rdata. Requesters must accept rvalid.
- A requester dropping req before grant is legal: no transfer occurs and the pointer is unaffected.
- Reset mid-operation: all in-flight reads are discarded with no rvalid, sram_valid drops immediately, and the pointer returns to 0.
- Binary-encoded request fields are don't-care while the matching req = 0.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index asserted req wins; the pointer register is removed; all other timing is identical.
- Undefined: round-robin as above.

Test Plan:
- Single write, then read:
  - Req0 writes addr 0x1234 with data 0xA5..A5 → gnt[0] in the same cycle, then sram_valid=1, sram_we=1, sram_addr=0x1234.
  - Req0 then reads 0x1234 → rvalid[0] 2 cycles after its accept with rdata=0xA5..A5.
- Contention: req[0] and req[1] both held for 4 cycles starting from reset → grants alternate 0,1,0,1; each requester gets exactly 2.
- Back-to-back reads:
  - Req1 reads 0x0000 and then req0 reads 0x7FFF on consecutive cycles → rvalid[1] then rvalid[0] on consecutive cycles, each carrying the correct data.
- Wrap-around, NUM_REQ=3: pointer=2 with req=3'b011 → gnt=3'b001, and the pointer becomes 1.
- Reset mid-read: rstn asserted 1 cycle after a read accept → no rvalid, all outputs 0; the first post-reset grant goes to req0.
- With SRAM_ARB_FIXED_PRIO_EN: req[0] and req[1] held continuously → gnt[0] every cycle, gnt[1] never.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter/sequencer sharing one single-port SRAM among NUM_REQ requesters.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority (pointer register removed).
module sram_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 256
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           sram_addr,
    output logic [DATA_W-1:0]           sram_din,
    output logic                        sram_we,
    output logic                        sram_valid,
    input  logic [DATA_W-1:0]           sram_dout
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      base, win;
    logic               any;
    logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]  sram_din_q, sram_din_d, rdata_q, rdata_d;
    logic               sram_we_q, sram_we_d, sram_valid_q, sram_valid_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic               t1_v_q, t1_v_d, t1_rd_q, t1_rd_d, t2_v_q, t2_v_d, t2_rd_q, t2_rd_d;
    logic [IW-1:0]      t1_idx_q, t1_idx_d, t2_idx_q, t2_idx_d;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;

    assign base = ptr_q;
    assign ptr_d = !any ? ptr_q : (int'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    // Search upward from base with wrap-around; first asserted req wins.
    always_comb begin
        int idx;
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(base) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (any) gnt[win] = 1'b1;
        sram_valid_d = any;
        sram_we_d    = any & req_we[win];
        sram_addr_d  = any ? req_addr[win*ADDR_W +: ADDR_W] : sram_addr_q;
        sram_din_d   = any ? req_wdata[win*DATA_W +: DATA_W] : sram_din_q;
        t1_v_d       = any;
        t1_rd_d      = ~req_we[win];
        t1_idx_d     = win;
        t2_v_d       = t1_v_q;
        t2_rd_d      = t1_rd_q;
        t2_idx_d     = t1_idx_q;
        rvalid_d     = '0;
        if (t2_v_q && t2_rd_q) rvalid_d[t2_idx_q] = 1'b1;
        rdata_d      = (t2_v_q && t2_rd_q) ? sram_dout : rdata_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
            sram_we_q    <= 1'b0;
            sram_valid_q <= 1'b0;
            t1_v_q       <= 1'b0;
            t1_rd_q      <= 1'b0;
            t1_idx_q     <= '0;
            t2_v_q       <= 1'b0;
            t2_rd_q      <= 1'b0;
            t2_idx_q     <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
        end else begin
            sram_addr_q  <= sram_addr_d;
            sram_din_q   <= sram_din_d;
            sram_we_q    <= sram_we_d;
            sram_valid_q <= sram_valid_d;
            t1_v_q       <= t1_v_d;
            t1_rd_q      <= t1_rd_d;
            t1_idx_q     <= t1_idx_d;
            t2_v_q       <= t2_v_d;
            t2_rd_q      <= t2_rd_d;
            t2_idx_q     <= t2_idx_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_din   = sram_din_q;
    assign sram_we    = sram_we_q;
    assign sram_valid = sram_valid_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of sram_arbiter (NUM_REQ=2 and NUM_REQ=3) against a behavioural SRAM.
module tb_sram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn;
    logic [1:0]   req, req_we, gnt, rvalid;
    logic [29:0]  req_addr;
    logic [511:0] req_wdata;
    logic [255:0] rdata, sram_din, sram_dout;
    logic [14:0]  sram_addr;
    logic         sram_we, sram_valid;

    logic [2:0]   req3, we3, gnt3, rv3;
    logic [44:0]  addr3;
    logic [767:0] wd3;
    logic [255:0] rdata3, din3, dout3;
    logic [14:0]  saddr3;
    logic         swe3, sval3;

    int total = 0;
    int bad = 0;
    int cnt0, cnt1;

    logic [255:0] mem [logic [14:0]];
    localparam logic [255:0] A5 = {32{8'hA5}};
    localparam logic [255:0] D0 = {8{32'h1111_2222}};
    localparam logic [255:0] DF = {8{32'hDEAD_BEEF}};

    sram_arbiter #(.NUM_REQ(2)) u_dut (
        .clk(clk), .rstn(rstn), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we),
        .sram_valid(sram_valid), .sram_dout(sram_dout)
    );

    sram_arbiter #(.NUM_REQ(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .req(req3), .req_we(we3), .req_addr(addr3),
        .req_wdata(wd3), .gnt(gnt3), .rvalid(rv3), .rdata(rdata3),
        .sram_addr(saddr3), .sram_din(din3), .sram_we(swe3),
        .sram_valid(sval3), .sram_dout(dout3)
    );

    // Behavioural SRAM: samples on the edge after sram_valid, read data valid the following cycle.
    always @(posedge clk) begin
        if (sram_valid) begin
            if (sram_we) mem[sram_addr] = sram_din;
            else sram_dout <= mem.exists(sram_addr) ? mem[sram_addr] : '0;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; sram_dout = '0;
        req3 = '0; we3 = '0; addr3 = '0; wd3 = '0; dout3 = '0;
        mem[15'h0000] = D0;
        mem[15'h7FFF] = DF;
        tick; tick;
        chk("rst_gnt", 256'(gnt), 256'(2'b00));
        chk("rst_rvalid", 256'(rvalid), 256'(2'b00));
        chk("rst_sram_valid", 256'(sram_valid), 256'(1'b0));
        chk("rst_sram_we", 256'(sram_we), 256'(1'b0));
        chk("rst_sram_addr", 256'(sram_addr), 256'(15'h0));
        chk("rst_rdata", rdata, '0);
        rstn = 1'b1;
        tick;

        // Single write then read-back of the same address
        req = 2'b01; req_we = 2'b01; req_addr[14:0] = 15'h1234; req_wdata[255:0] = A5;
        #1 chk("wr_gnt", 256'(gnt), 256'(2'b01));
        tick;
        chk("wr_sram_valid", 256'(sram_valid), 256'(1'b1));
        chk("wr_sram_we", 256'(sram_we), 256'(1'b1));
        chk("wr_sram_addr", 256'(sram_addr), 256'(15'h1234));
        chk("wr_sram_din", sram_din, A5);
        req_we = 2'b00;
        #1 chk("rd_gnt", 256'(gnt), 256'(2'b01));
        tick;
        chk("rd_sram_valid", 256'(sram_valid), 256'(1'b1));
        chk("rd_sram_we", 256'(sram_we), 256'(1'b0));
        req = 2'b00;
        tick;
        chk("rd_rvalid_early", 256'(rvalid), 256'(2'b00));
        tick;
        chk("rd_rvalid", 256'(rvalid), 256'(2'b01));
        chk("rd_rdata", rdata, A5);
        tick;
        chk("rd_rvalid_pulse", 256'(rvalid), 256'(2'b00));
        chk("idle_sram_valid", 256'(sram_valid), 256'(1'b0));

        // Contention from reset: both requesters held for 4 cycles
        rstn = 1'b0; tick; rstn = 1'b1; tick;
        cnt0 = 0; cnt1 = 0;
        req = 2'b11; req_we = 2'b11; req_addr = {15'h0101, 15'h0100};
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
            chk($sformatf("cont_gnt%0d", i), 256'(gnt), 256'(2'b01));
`else
            chk($sformatf("cont_gnt%0d", i), 256'(gnt), 256'((i % 2 == 0) ? 2'b01 : 2'b10));
`endif
            cnt0 += int'(gnt[0]);
            cnt1 += int'(gnt[1]);
            tick;
        end
        req = 2'b00;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        chk("cont_cnt0", 256'(cnt0), 256'(4));
        chk("cont_cnt1", 256'(cnt1), 256'(0));
`else
        chk("cont_cnt0", 256'(cnt0), 256'(2));
        chk("cont_cnt1", 256'(cnt1), 256'(2));
`endif
        tick;

        // Back-to-back reads from different requesters
        req = 2'b10; req_we = 2'b00; req_addr = {15'h0000, 15'h7FFF};
        #1 chk("b2b_gnt1", 256'(gnt), 256'(2'b10));
        tick;
        req = 2'b01;
        #1 chk("b2b_gnt0", 256'(gnt), 256'(2'b01));
        tick;
        req = 2'b00;
        tick;
        chk("b2b_rvalid1", 256'(rvalid), 256'(2'b10));
        chk("b2b_rdata1", rdata, D0);
        tick;
        chk("b2b_rvalid0", 256'(rvalid), 256'(2'b01));
        chk("b2b_rdata0", rdata, DF);
        tick;
        chk("b2b_rvalid_end", 256'(rvalid), 256'(2'b00));

        // Wrap-around on the 3-requester instance
        req3 = 3'b010; we3 = 3'b111;
        #1 chk("wrap_gnt_a", 256'(gnt3), 256'(3'b010));
        tick;
        req3 = 3'b011;
        #1 chk("wrap_gnt_b", 256'(gnt3), 256'(3'b001));
        tick;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        #1 chk("wrap_gnt_c", 256'(gnt3), 256'(3'b001));
`else
        #1 chk("wrap_gnt_c", 256'(gnt3), 256'(3'b010));
`endif
        tick;
        req3 = 3'b000;
        tick;

        // Reset while a read is in flight
        req = 2'b01; req_we = 2'b00; req_addr[14:0] = 15'h1234;
        #1 chk("rr_gnt", 256'(gnt), 256'(2'b01));
        tick;
        req = 2'b00;
        chk("rr_sram_valid_pre", 256'(sram_valid), 256'(1'b1));
        rstn = 1'b0;
        #1;
        chk("rr_sram_valid", 256'(sram_valid), 256'(1'b0));
        chk("rr_sram_addr", 256'(sram_addr), 256'(15'h0));
        chk("rr_rdata", rdata, '0);
        tick;
        chk("rr_rvalid_a", 256'(rvalid), 256'(2'b00));
        tick;
        chk("rr_rvalid_b", 256'(rvalid), 256'(2'b00));
        rstn = 1'b1;
        tick;
        chk("rr_rvalid_c", 256'(rvalid), 256'(2'b00));
        req = 2'b11;
        #1 chk("rr_first_gnt", 256'(gnt), 256'(2'b01));
        tick;
        req = 2'b00;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
